// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    typedef logic [1:0] sel_id_t;

    localparam int COIN5_VAL   = 5;
    localparam int COIN10_VAL  = 10;
    localparam int CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - coin/keypad/dispenser/hopper signal bundle for the vending controller
interface vend_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
);
    logic                coin5;
    logic                coin10;
    logic                sel_valid;
    sel_id_t             sel_id;
    logic                cancel;
    logic                disp_req;
    logic                disp_done;
    logic                chg_req;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                sel_nack;
    logic                busy;

    modport master (
        output coin5, coin10, sel_valid, sel_id, cancel, disp_done, chg_ack,
        input  disp_req, chg_req, credit, coin_reject, sel_nack, busy
    );

    modport slave (
        input  coin5, coin10, sel_valid, sel_id, cancel, disp_done, chg_ack,
        output disp_req, chg_req, credit, coin_reject, sel_nack, busy
    );
endinterface

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - idle-credit timeout counter, instantiated only under VEND_TIMEOUT_EN
module vend_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending transaction sequencer; optional idle timeout under VEND_TIMEOUT_EN
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W       = 8,
    parameter int MAX_CREDIT     = 50,
    parameter int PRICE0         = 15,
    parameter int PRICE1         = 20,
    parameter int PRICE2         = 25,
    parameter int PRICE3         = 30,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic  clk,
    input  logic  reset_n,
    vend_if.slave bus
);
    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_coin_reject;
    logic                r_sel_nack;

    logic                w_coin_any;
    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_fits;
    logic [CREDIT_W-1:0] w_price;
    logic                w_afford;
    logic                w_timeout;

    // Parameter sanity is checked at elaboration so a bad build never reaches silicon.
    if (MAX_CREDIT >= 2**CREDIT_W) begin : g_bad_credit_w
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign w_coin_any  = bus.coin5 | bus.coin10;
    assign w_coin_val  = bus.coin10 ? (CREDIT_W+1)'(COIN10_VAL) : (CREDIT_W+1)'(COIN5_VAL);
    assign w_sum       = {1'b0, r_credit} + w_coin_val;
    assign w_coin_fits = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_afford    = (r_credit >= w_price);

    always_comb begin
        w_price = CREDIT_W'(PRICE0);
        case (bus.sel_id)
            2'd0:    w_price = CREDIT_W'(PRICE0);
            2'd1:    w_price = CREDIT_W'(PRICE1);
            2'd2:    w_price = CREDIT_W'(PRICE2);
            default: w_price = CREDIT_W'(PRICE3);
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    logic w_in_credit;
    logic w_timer_clear;

    // Any customer activity in CREDIT restarts the idle window.
    assign w_in_credit   = (r_state == CREDIT);
    assign w_timer_clear = !w_in_credit
                         | (!bus.cancel && !bus.sel_valid && w_coin_any && w_coin_fits)
                         | (!bus.cancel && bus.sel_valid && !w_afford);

    vend_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_in_credit),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
            r_sel_nack    <= 1'b0;
        end else begin
            r_coin_reject <= 1'b0;
            r_sel_nack    <= 1'b0;
            case (r_state)
                IDLE, CREDIT: begin
                    if (bus.cancel) begin
                        r_coin_reject <= w_coin_any;
                        if (r_state == CREDIT) r_state <= CHANGE;
                    end else if (bus.sel_valid) begin
                        r_coin_reject <= w_coin_any;
                        if (r_state == CREDIT && w_afford) begin
                            r_credit <= r_credit - w_price;
                            r_state  <= DISPENSE;
                        end else begin
                            r_sel_nack <= 1'b1;
                        end
                    end else if (w_coin_any) begin
                        // coin10 wins a same-cycle pair, so coin5 goes back to the chute.
                        if (w_coin_fits) begin
                            r_credit      <= w_sum[CREDIT_W-1:0];
                            r_state       <= CREDIT;
                            r_coin_reject <= bus.coin5 & bus.coin10;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= CHANGE;
                    end
                end
                DISPENSE: begin
                    r_coin_reject <= w_coin_any;
                    r_sel_nack    <= bus.sel_valid;
                    if (bus.disp_done) begin
                        r_state <= (r_credit != '0) ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    r_coin_reject <= w_coin_any;
                    r_sel_nack    <= bus.sel_valid;
                    if (bus.chg_ack) begin
                        r_credit <= r_credit - CREDIT_W'(CHANGE_UNIT);
                        if (r_credit == CREDIT_W'(CHANGE_UNIT)) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.disp_req    = (r_state == DISPENSE);
    assign bus.chg_req     = (r_state == CHANGE);
    assign bus.busy        = (r_state == DISPENSE) || (r_state == CHANGE);
    assign bus.credit      = r_credit;
    assign bus.coin_reject = r_coin_reject;
    assign bus.sel_nack    = r_sel_nack;
endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller
module tb_vend_controller;
    import vend_pkg::*;

    typedef struct {
        bit rst_n;
        bit c5;
        bit c10;
        bit sv;
        int sid;
        bit can;
        bit dd;
        bit ack;
        int e_credit;
        bit e_dreq;
        bit e_creq;
        bit e_nack;
        bit e_rej;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vend_if #(.CREDIT_W(8)) bus ();

    vend_controller #(
        .CREDIT_W       (8),
        .MAX_CREDIT     (50),
        .PRICE0         (15),
        .PRICE1         (20),
        .PRICE2         (25),
        .PRICE3         (30),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(bit rn, bit c5, bit c10, bit sv, int sid, bit can, bit dd,
                                bit ack, int cr, bit dq, bit cq, bit nk, bit rj);
        vec_t v;
        v.rst_n = rn; v.c5 = c5; v.c10 = c10; v.sv = sv; v.sid = sid; v.can = can;
        v.dd = dd; v.ack = ack; v.e_credit = cr; v.e_dreq = dq; v.e_creq = cq;
        v.e_nack = nk; v.e_rej = rj;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        reset_n       = 1'b1;
        bus.coin5     = 1'b0;
        bus.coin10    = 1'b0;
        bus.sel_valid = 1'b0;
        bus.sel_id    = 2'd0;
        bus.cancel    = 1'b0;
        bus.disp_done = 1'b0;
        bus.chg_ack   = 1'b0;
    endtask

    task automatic step(input bit c5, input bit c10, input bit sv, input int sid, input bit can,
                        input bit dd, input bit ack);
        bus.coin5 = c5; bus.coin10 = c10; bus.sel_valid = sv; bus.sel_id = sel_id_t'(sid);
        bus.cancel = can; bus.disp_done = dd; bus.chg_ack = ack;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   n;
        int   acks;
        int   cyc;
        clear_inputs();
        reset_n = 1'b0;

        //            rn c5 c10 sv sid can dd ack  cr dq cq nk rj
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 10, 1, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 10, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  5, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  5, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0, 10, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 10, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  5, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 40, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 45, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 45, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 50, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 50, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 20, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 15, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 10, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 1,  5, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 15, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            reset_n = v.rst_n;
            bus.coin5 = v.c5; bus.coin10 = v.c10; bus.sel_valid = v.sv;
            bus.sel_id = sel_id_t'(v.sid); bus.cancel = v.can;
            bus.disp_done = v.dd; bus.chg_ack = v.ack;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("row%0d credit", i),  int'(bus.credit),      e.e_credit);
            check($sformatf("row%0d disp_req", i), int'(bus.disp_req),   int'(e.e_dreq));
            check($sformatf("row%0d chg_req", i), int'(bus.chg_req),     int'(e.e_creq));
            check($sformatf("row%0d busy", i),    int'(bus.busy),        int'(e.e_dreq | e.e_creq));
            check($sformatf("row%0d sel_nack", i), int'(bus.sel_nack),   int'(e.e_nack));
            check($sformatf("row%0d coin_reject", i), int'(bus.coin_reject), int'(e.e_rej));
            clear_inputs();
        end

        // Slow dispenser and an irregular hopper: 30 credit, product 0 leaves 15 = three coins.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("slow disp_req", int'(bus.disp_req), 1);
        check("slow credit", int'(bus.credit), 15);
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("slow disp_req held", int'(bus.disp_req), 1);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        check("slow chg_req", int'(bus.chg_req), 1);
        acks = 0;
        cyc = 0;
        while (bus.chg_req && cyc < 50) begin
            n = $urandom_range(0, 1);
            step(0, 0, 0, 0, 0, 0, n[0]);
            if (n[0]) acks++;
            cyc++;
        end
        check("slow change done in budget", int'(cyc < 50), 1);
        check("slow ack count", acks, 3);
        check("slow final credit", int'(bus.credit), 0);
        check("slow busy", int'(bus.busy), 0);

`ifdef VEND_TIMEOUT_EN
        step(1, 0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (!bus.chg_req && cyc < 30) begin
            step(0, 0, 0, 0, 0, 0, 0);
            cyc++;
        end
        check("timeout edges to CHANGE", cyc, 8);
        step(0, 0, 0, 0, 0, 0, 1);
        check("timeout refund credit", int'(bus.credit), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction sequencer for a 4-product vending unit.
- Accumulates coin credit, arbitrates selection/cancel/coin events, drives the dispenser mechanism through a req/done handshake, then returns change as 5-unit coins through a req/ack handshake.
- Sits between the coin acceptor front end, the product keypad and the dispenser/change-hopper actuators.

Parameters:
- CREDIT_W, 8, width of credit register; MAX_CREDIT must be < 2**CREDIT_W.
- MAX_CREDIT, 50, credit ceiling; a coin that would exceed it is rejected.
- PRICE0, 15, price of product 0 (multiple of 5).
- PRICE1, 20, price of product 1.
- PRICE2, 25, price of product 2.
- PRICE3, 30, price of product 3.
- TIMEOUT_CYCLES, 1000, idle-credit timeout; used only with VEND_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- coin5  in  1  one-cycle pulse, 5-unit coin inserted.
- coin10  in  1  one-cycle pulse, 10-unit coin inserted.
- sel_valid  in  1  one-cycle pulse, product selection.
- sel_id  in  2  product index, valid with sel_valid.
- cancel  in  1  one-cycle pulse, refund request.
- disp_req  out  1  dispense request; held until disp_done.
- disp_done  in  1  dispenser completion pulse.
- chg_req  out  1  change-coin request; each ack returns one 5-unit coin.
- chg_ack  in  1  hopper ejected one coin.
- credit  out  CREDIT_W  current credit.
- coin_reject  out  1  one-cycle pulse, coin refused and routed to return chute.
- sel_nack  out  1  one-cycle pulse, selection refused (insufficient credit or busy).
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset: all logic is synchronous; reset_n=0 at a rising edge forces state=IDLE, credit=0 and all outputs 0. Mid-transaction reset abandons dispense/change with no refund.
- State register: enum IDLE, CREDIT, DISPENSE, CHANGE.
- Output decode: disp_req=(state==DISPENSE), chg_req=(state==CHANGE), busy=DISPENSE|CHANGE, all decoded from the state register. coin_reject and sel_nack are registered and appear the cycle after the event.
- Event priority per cycle in IDLE/CREDIT: cancel > sel_valid > coin10 > coin5. Any coin not accepted that cycle pulses coin_reject, including coin5 when coin10 is accepted and coins arriving with sel_valid or cancel.
- IDLE:
  - Accepted coin: credit += value, go to CREDIT.
  - sel_valid: sel_nack.
  - cancel: ignored.
- CREDIT, coin: coin accepted if credit+value <= MAX_CREDIT (compute in CREDIT_W+1 bits), else coin_reject and credit unchanged.
- CREDIT, sel_valid:
  - If credit >= PRICE[sel_id]: credit -= price at the same edge, go to DISPENSE.
  - Otherwise: sel_nack, stay in CREDIT.
- CREDIT, cancel: go to CHANGE. Credit is always nonzero in CREDIT.
- DISPENSE:
  - disp_req held high until disp_done sampled high.
  - Then go to CHANGE if credit != 0, else IDLE.
  - Coins are rejected; sel_valid gives sel_nack; cancel is ignored.
- CHANGE:
  - Each cycle with chg_ack=1: credit -= 5.
  - When credit becomes 0, go to IDLE at that edge.
  - Coins are rejected; sel_valid gives sel_nack; cancel is ignored.
  - chg_ack outside CHANGE is ignored.
- Latency:
  - Selection pulse to disp_req high: 1 cycle.
  - disp_done to chg_req high (or IDLE): 1 cycle.
- Invariants: credit is always a multiple of 5 and always <= MAX_CREDIT.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter clears on reset, on entry to CREDIT and on any accepted coin or sel_nack event in CREDIT.
  - It increments each CREDIT cycle.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to CHANGE, the same as cancel.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter; credit is held in CREDIT indefinitely and the TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Shared package vend_pkg:
  - state_t enum (IDLE, CREDIT, DISPENSE, CHANGE).
  - COIN5_VAL=5 and COIN10_VAL=10 constants.
  - CHANGE_UNIT=5.
  - sel_id_t (2-bit) typedef.
- Sub-module vend_timer: the timeout counter, instantiated only under VEND_TIMEOUT_EN. Price lookup stays as an inline case on sel_id.

Test Plan:
- Reset, then coin10, coin5, sel_id=0 -> credit 10 then 15; disp_req high 1 cycle after sel; disp_done -> credit 0, back to IDLE, no chg_req.
- Coins 10,10,10, sel_id=1 -> credit 30 drops to 10, DISPENSE; disp_done -> chg_req high; two chg_ack pulses -> credit 5 then 0, IDLE.
- Credit 10, sel_id=3 -> sel_nack pulse, credit stays 10, state CREDIT.
- Credit 45, coin10 -> coin_reject, credit 45; then coin5 -> credit 50.
- Same-cycle coin5+coin10 in IDLE -> credit 10, coin_reject pulse. Same-cycle cancel+sel_valid at credit 20 -> CHANGE, four acks -> credit 0.
- reset_n low during CHANGE at credit 15 -> next edge credit 0, chg_req 0, IDLE. With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8: coin5 then idle -> CHANGE after 8 cycles.
